bullet_fire_ctrl: RTL and testbench
===================================

Name: bullet_fire_ctrl

Overview:
- Fire scheduler for the player's pool of bullet slots. Each slot is one bullet datapath instance that flies from the player toward the enemy and reports whether it exists and whether it has hit.
- Turns the player's attack/defend inputs into one-cycle launch pulses to a free slot.
- Enforces a fire cooldown and a magazine with timed reload.
- Aggregates per-slot hit reports into a hit event and a hit counter for the score and HP logic.

Parameters:
- NUM_SLOTS, 4, number of bullet slots managed (1..8).
- COOLDOWN_TICKS, 8, ticks spent in COOLDOWN after a shot.
- AMMO_MAX, 6, magazine size (1..15).
- RELOAD_TICKS, 32, ticks spent in RELOAD after the last round is fired.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-frame strobe; all fire decisions and timers advance only on tick.
- clear  in  1  synchronous round restart; highest priority after reset.
- attack  in  1  player attack request, level.
- defend  in  1  player defend, level; blocks firing.
- slotBusy  in  NUM_SLOTS  per-slot bullet-exists flag.
- slotHit  in  NUM_SLOTS  per-slot one-cycle hit pulse.
- fire  out  NUM_SLOTS  one-hot launch pulse to a slot, registered.
- ammo  out  4  rounds remaining.
- reloading  out  1  high while state is RELOAD.
- ready  out  1  high when state is IDLE, ammo>0 and at least one slot is free.
- hitPulse  out  1  registered; high one cycle after any slotHit bit is high.
- hitCount  out  8  total hits, saturating at 255.

Behaviour:
- Reset and clear values: state IDLE, fire=0, ammo=AMMO_MAX, counter=0, hitPulse=0, hitCount=0, reservation mask=0. clear applies the same values on the next edge, overriding every event in that cycle, including hits.
- States: IDLE, COOLDOWN, RELOAD.
- Slot free condition: slot i is free iff slotBusy[i]=0 and reserved[i]=0. reserved[i] is set in the cycle fire[i] is driven and cleared the next cycle, covering the slot's one-cycle flag latency.
- Selection: lowest-index free slot wins.
- Fire condition: evaluated only in IDLE on a cycle with tick=1. Fires iff attack=1, defend=0, ammo>0 and a free slot exists.
- Fire effect:
  - On the next edge, fire[sel] goes high for exactly one cycle and ammo decrements by 1.
  - If the new ammo is 0: state becomes RELOAD and the counter loads RELOAD_TICKS.
  - Otherwise: state becomes COOLDOWN and the counter loads COOLDOWN_TICKS.
- Fire latency: a tick at cycle t gives fire high at cycle t+1. No fire is issued on a non-tick cycle.
- COOLDOWN: on each tick, if counter==1 go to IDLE, else decrement. For a shot fired on tick F, the earliest next shot is tick F+COOLDOWN_TICKS+1. attack and defend are ignored while in COOLDOWN.
- RELOAD: same countdown rule using RELOAD_TICKS. On leaving RELOAD, ammo=AMMO_MAX in the same edge.
- No fire when no slot is free: if all slots are busy or reserved, no fire, state stays IDLE, ammo unchanged. The request is not queued; it is re-evaluated on the next tick.
- defend: defend=1 in IDLE suppresses firing only. Timers keep running in the other states.
- Hits:
  - hitPulse is registered as the OR of slotHit, so it follows a hit by one cycle.
  - hitCount adds the popcount of slotHit, so simultaneous hits all count, saturating at 255.
  - Hits are counted in every state and independently of tick.
- A fire and a hit in the same cycle are both processed.
- Parameter bounds: COOLDOWN_TICKS and RELOAD_TICKS must be at least 1. The counter is wide enough for max(COOLDOWN_TICKS, RELOAD_TICKS).
- ready is combinational from registered state, ammo and the free mask.

Test Plan:
- Single shot: after reset, hold attack=1, tick every 4 cycles, all slots idle → fire=0001 one cycle after the first tick, ammo 6→5. The next fire comes on tick F+9.
- Magazine: hold attack with slots free → 6 shots, then reloading=1 for 32 ticks. ammo=6 on exit, and the next shot comes on the following tick.
- Slot exhaustion: NUM_SLOTS=4, slotBusy=1111, attack=1 → no fire, ammo unchanged, ready=0. Drop slotBusy[2] → fire=0100 on the next tick.
- Defend and reservation: defend=1 with attack=1 for 20 ticks → no fire. With tick on consecutive cycles and COOLDOWN_TICKS=1, slot 0 busy late (slotBusy lags) → the second shot goes to slot 1, not slot 0.
- Hits: slotHit=1011 in one cycle → hitPulse=1 next cycle and hitCount +3. Preload to 254, then slotHit=0011 → 255. Asserting clear at the same time as a hit → hitCount=0.
- Async reset mid-RELOAD: drop rst_n → state IDLE, ammo=6, fire=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bullet_fire_ctrl.sv
// Fire scheduler for the player's bullet slots: launches bullets into free slots,
// enforces cooldown and magazine reload, and aggregates slot hit reports.
module bullet_fire_ctrl #(
    parameter int NUM_SLOTS      = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int AMMO_MAX       = 6,
    parameter int RELOAD_TICKS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 clear,
    input  logic                 attack,
    input  logic                 defend,
    input  logic [NUM_SLOTS-1:0] slotBusy,
    input  logic [NUM_SLOTS-1:0] slotHit,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [3:0]           ammo,
    output logic                 reloading,
    output logic                 ready,
    output logic                 hitPulse,
    output logic [7:0]           hitCount
);

    localparam int MAX_TICKS = (COOLDOWN_TICKS > RELOAD_TICKS) ? COOLDOWN_TICKS : RELOAD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COOLDOWN,
        ST_RELOAD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           ammo_q, ammo_d;
    logic [NUM_SLOTS-1:0] fire_q, fire_d;
    logic [NUM_SLOTS-1:0] reserved_q;
    logic                 hit_pulse_q;
    logic [7:0]           hit_count_q, hit_count_d;

    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] sel_onehot;
    logic                 any_free;
    logic                 can_fire;
    logic [8:0]           hit_sum;

    function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // A slot just launched is held reserved for one cycle, until its busy flag catches up.
    assign free_mask = ~slotBusy & ~reserved_q;
    assign any_free  = |free_mask;

    always_comb begin
        sel_onehot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign can_fire = (state_q == ST_IDLE) && tick && attack && !defend
                      && (ammo_q != 4'd0) && any_free;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ammo_d  = ammo_q;
        fire_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (can_fire) begin
                    fire_d = sel_onehot;
                    ammo_d = ammo_q - 4'd1;
                    if (ammo_q == 4'd1) begin
                        state_d = ST_RELOAD;
                        cnt_d   = CNT_W'(RELOAD_TICKS);
                    end else begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = CNT_W'(COOLDOWN_TICKS);
                    end
                end
            end
            ST_COOLDOWN, ST_RELOAD: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_RELOAD) begin
                            ammo_d = 4'(AMMO_MAX);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hits are tallied every cycle, independent of tick and state; the count saturates.
    assign hit_sum     = {1'b0, hit_count_q} + {5'b00000, popcount(slotHit)};
    assign hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ammo_q      <= 4'(AMMO_MAX);
            fire_q      <= '0;
            reserved_q  <= '0;
            hit_pulse_q <= 1'b0;
            hit_count_q <= '0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ammo_q      <= 4'(AMMO_MAX);
            fire_q      <= '0;
            reserved_q  <= '0;
            hit_pulse_q <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ammo_q      <= ammo_d;
            fire_q      <= fire_d;
            reserved_q  <= fire_d;
            hit_pulse_q <= |slotHit;
            hit_count_q <= hit_count_d;
        end
    end

    assign fire      = fire_q;
    assign ammo      = ammo_q;
    assign reloading = (state_q == ST_RELOAD);
    assign ready     = (state_q == ST_IDLE) && (ammo_q != 4'd0) && any_free;
    assign hitPulse  = hit_pulse_q;
    assign hitCount  = hit_count_q;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Bench for bullet_fire_ctrl: a tick-indexed reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bullet_fire_ctrl;

    localparam int C = 8;
    localparam int R = 32;
    localparam int A = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick, clear, attack, defend;
    logic [3:0] slot_busy, slot_hit;
    logic [3:0] fire, ammo;
    logic       reloading, ready, hit_pulse;
    logic [7:0] hit_count;

    logic       c1_tick, c1_attack;
    logic [3:0] c1_busy, c1_fire, c1_ammo;
    logic       c1_reloading, c1_ready, c1_hit_pulse;
    logic [7:0] c1_hit_count;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    bullet_fire_ctrl #(.NUM_SLOTS(4), .COOLDOWN_TICKS(C), .AMMO_MAX(A), .RELOAD_TICKS(R)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear), .attack(attack), .defend(defend),
        .slotBusy(slot_busy), .slotHit(slot_hit), .fire(fire), .ammo(ammo),
        .reloading(reloading), .ready(ready), .hitPulse(hit_pulse), .hitCount(hit_count)
    );

    bullet_fire_ctrl #(.NUM_SLOTS(4), .COOLDOWN_TICKS(1), .AMMO_MAX(A), .RELOAD_TICKS(R)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .tick(c1_tick), .clear(1'b0), .attack(c1_attack), .defend(1'b0),
        .slotBusy(c1_busy), .slotHit(4'b0000), .fire(c1_fire), .ammo(c1_ammo),
        .reloading(c1_reloading), .ready(c1_ready), .hitPulse(c1_hit_pulse), .hitCount(c1_hit_count)
    );

    // Slots of the second instance raise busy one cycle after launch and never land.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c1_busy <= 4'b0000;
        else        c1_busy <= c1_busy | c1_fire;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: shots are scheduled by tick index rather than by a countdown.
    int         m_ticks, m_next_ok, m_refill_at, m_ammo, m_hits;
    logic [3:0] m_fire;
    logic       m_hit_pulse;
    int         t_a, t_h;
    logic [3:0] t_f, t_free;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_ticks     <= 0;
            m_next_ok   <= 0;
            m_refill_at <= -1;
            m_ammo      <= A;
            m_fire      <= 4'b0000;
            m_hits      <= 0;
            m_hit_pulse <= 1'b0;
        end else begin
            t_a    = m_ammo;
            t_f    = 4'b0000;
            t_free = ~slot_busy & ~m_fire;
            t_h    = m_hits + $countones(slot_hit);
            m_hits      <= (t_h > 255) ? 255 : t_h;
            m_hit_pulse <= |slot_hit;
            if (tick) begin
                if (m_ticks == m_refill_at) t_a = A;
                if (m_ticks >= m_next_ok && attack && !defend && t_a > 0 && t_free != 4'b0000) begin
                    for (int i = 3; i >= 0; i--) if (t_free[i]) t_f = 4'b0001 << i;
                    t_a = t_a - 1;
                    if (t_a == 0) begin
                        m_refill_at <= m_ticks + R;
                        m_next_ok   <= m_ticks + R + 1;
                    end else begin
                        m_next_ok   <= m_ticks + C + 1;
                    end
                end
                m_ticks <= m_ticks + 1;
            end
            m_ammo <= t_a;
            m_fire <= t_f;
        end
    end

    always @(negedge clk) begin
        check("fire", fire, m_fire);
        check("ammo", ammo, m_ammo);
        check("reloading", reloading, (m_refill_at >= m_ticks));
        check("ready", ready, (m_ticks >= m_next_ok) && (m_ammo > 0)
                              && ((~slot_busy & ~m_fire) != 4'b0000));
        check("hitPulse", hit_pulse, m_hit_pulse);
        check("hitCount", hit_count, m_hits);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick every four cycles; returns fire as seen just after the tick's edge.
    task automatic do_tick(output logic [3:0] f);
        tick = 1'b1;
        step();
        tick = 1'b0;
        f = fire;
        step();
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] f;
        logic [3:0] c1_seq [8];
        logic [3:0] c1_exp [8];
        int         fired [$];
        int         exp_fired [7];
        int         rel_count, nf;
        bit         done;

        tick = 0; clear = 0; attack = 0; defend = 0; slot_busy = 0; slot_hit = 0;
        c1_tick = 0; c1_attack = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("reset ammo", ammo, 6);
        check("reset fire", fire, 0);
        check("reset hitCount", hit_count, 0);
        check("reset ready", ready, 1);

        // Consecutive ticks with a one-tick cooldown: slot 0 shows busy a cycle late, so shot two goes to slot 1.
        c1_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        c1_attack = 1'b1;
        c1_tick = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            c1_seq[k] = c1_fire;
        end
        for (int k = 0; k < 8; k++) check($sformatf("c1 fire[%0d]", k), c1_seq[k], c1_exp[k]);
        step();
        step();
        check("c1 all busy no fire", c1_fire, 0);
        check("c1 ammo", c1_ammo, 2);
        check("c1 ready", c1_ready, 0);
        c1_attack = 1'b0;
        c1_tick = 1'b0;

        // Single shot, cooldown spacing, then a full magazine and reload.
        exp_fired = '{0, 9, 18, 27, 36, 45, 78};
        attack = 1'b1;
        rel_count = 0;
        for (int k = 0; k <= 78; k++) begin
            if (reloading) rel_count++;
            do_tick(f);
            if (k == 0) begin
                check("first fire", f, 4'b0001);
                check("ammo after first", ammo, 5);
            end
            if (f != 4'b0000) fired.push_back(k);
        end
        check("shot count", fired.size(), 7);
        for (int i = 0; i < 7 && i < fired.size(); i++) check($sformatf("shot tick[%0d]", i), fired[i], exp_fired[i]);
        check("reload ticks", rel_count, 32);
        check("ammo after refill shot", ammo, 5);

        // Slot exhaustion.
        attack = 1'b0;
        repeat (9) do_tick(f);
        slot_busy = 4'b1111;
        attack = 1'b1;
        step();
        check("ready all busy", ready, 0);
        nf = 0;
        repeat (3) begin
            do_tick(f);
            if (f != 4'b0000) nf++;
        end
        check("no fire all busy", nf, 0);
        check("ammo all busy", ammo, 5);
        slot_busy = 4'b1011;
        step();
        check("ready slot2 free", ready, 1);
        do_tick(f);
        check("fire slot2", f, 4'b0100);
        check("ammo after slot2", ammo, 4);
        attack = 1'b0;
        slot_busy = 4'b0000;

        // Defend blocks firing.
        repeat (9) do_tick(f);
        defend = 1'b1;
        attack = 1'b1;
        nf = 0;
        repeat (20) begin
            do_tick(f);
            if (f != 4'b0000) nf++;
        end
        check("defend no fire", nf, 0);
        check("defend ammo", ammo, 4);
        defend = 1'b0;
        attack = 1'b0;

        // Hits: simultaneous count, saturation, clear overriding a hit.
        slot_hit = 4'b1011;
        step();
        slot_hit = 4'b0000;
        check("hitPulse after hit", hit_pulse, 1);
        check("hitCount +3", hit_count, 3);
        step();
        check("hitPulse drops", hit_pulse, 0);
        slot_hit = 4'b1111;
        repeat (62) step();
        slot_hit = 4'b0011;
        step();
        slot_hit = 4'b0001;
        step();
        slot_hit = 4'b0000;
        check("hitCount preload", hit_count, 254);
        slot_hit = 4'b0011;
        step();
        check("hitCount saturate", hit_count, 255);
        slot_hit = 4'b1111;
        step();
        check("hitCount stays", hit_count, 255);
        clear = 1'b1;
        step();
        clear = 1'b0;
        slot_hit = 4'b0000;
        check("clear hitCount", hit_count, 0);
        check("clear ammo", ammo, 6);

        // Empty the magazine, then reset asynchronously right on the last launch.
        attack = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (fire != 4'b0000 && reloading) done = 1'b1;
            else begin
                step();
                step();
                step();
            end
        end
        check("reached reload", done, 1);
        check("ammo empty", ammo, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async fire", fire, 0);
        check("async ammo", ammo, 6);
        check("async reloading", reloading, 0);
        attack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
